cle_key_reader: RTL

Bus-side controller that sequences the CLE1C8 key device. On request it wins the shared bus and drives the key's select and address lines through a fixed unlock address pattern. It then clocks out KEY_BITS serial bits from SDRD into a parallel register for the host. It sits between the host request logic and the BA/BR_W/SSER bus that the key device decodes.

---
 rtl/cle_key_reader_pkg.sv | 27 ++
 rtl/cle_key_reader_if.sv | 22 ++
 rtl/cle_key_reader_access_cycle.sv | 59 +++++
 rtl/cle_key_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cle_key_reader_pkg.sv
// cle_key_pkg: shared constants and types for the CLE1C8 key reader.
//   - FSM state codes (IDLE, REQ, UNLOCK, READ, RELEASE, FAIL)
//   - unlock address nibble table and key address window
//   - access phase encoding used by cle_access_cycle
package cle_key_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_UNLOCK  = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;

    // BA13..BA12 select the key device window on every access
    localparam logic [1:0] KEY_WIN = 2'b01;

    // BA7..BA4 unlock pattern, entry 0 is presented first
    localparam logic [3:0][3:0] UNLOCK_TBL = {4'h9, 4'hA, 4'h8, 4'h2};

    // phase A: address out, select idle; phase B: select asserted
    typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_e;

    function automatic logic [3:0] unlock_nib(input logic [1:0] idx);
        return UNLOCK_TBL[idx];
    endfunction

endpackage

// File: rtl/cle_key_reader_if.sv
// cle_key_reader_if: host handshake plus key-device bus bundle.
//   host : start (in), busy/done/error/key_data (out)
//   bus  : bus_req (out), bus_gnt (in), ba/br_w/sser_n (out), sdrd (in)
// master = the reader controller, slave = host/arbiter/key side.
interface cle_key_reader_if #(parameter int KEY_BITS = 16);
    logic                start;
    logic                busy;
    logic                done;
    logic                error;
    logic [KEY_BITS-1:0] key_data;
    logic                bus_req;
    logic                bus_gnt;
    logic [9:0]          ba;
    logic                br_w;
    logic                sser_n;
    logic                sdrd;

    modport master (input start, bus_gnt, sdrd,
                    output busy, done, error, key_data, bus_req, ba, br_w, sser_n);
    modport slave  (output start, bus_gnt, sdrd,
                    input busy, done, error, key_data, bus_req, ba, br_w, sser_n);
endinterface

// File: rtl/cle_key_reader_access_cycle.sv
// cle_access_cycle: two-clock key access sequencer.
//   go      - load a new access (phase A next clock) with address nibble
//   abort   - drop any access in flight, return to idle outputs
//   capture - qualifies the sample strobe (only read accesses carry data)
//   sser_n  - registered key select, low only in phase B
//   ba_nib  - registered BA7..BA4, 0 when idle
//   active  - an access is on the bus (phase A or B)
//   last_ph - current clock is phase B; the key advances on its ending edge
//   sample  - last_ph qualified by capture: sample sdrd on this edge
module cle_access_cycle
    import cle_key_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    input  logic       capture,
    input  logic [3:0] nibble,
    output logic       sser_n,
    output logic [3:0] ba_nib,
    output logic       active,
    output logic       sample,
    output logic       last_ph
);

    phase_e ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            ph     <= PH_A;
            sser_n <= 1'b1;
            ba_nib <= 4'h0;
        end else if (abort) begin
            active <= 1'b0;
            ph     <= PH_A;
            sser_n <= 1'b1;
            ba_nib <= 4'h0;
        end else if (go) begin
            // back-to-back accesses reload here on the edge ending phase B
            active <= 1'b1;
            ph     <= PH_A;
            sser_n <= 1'b1;
            ba_nib <= nibble;
        end else if (active && ph == PH_A) begin
            ph     <= PH_B;
            sser_n <= 1'b0;
        end else begin
            active <= 1'b0;
            ph     <= PH_A;
            sser_n <= 1'b1;
            ba_nib <= 4'h0;
        end
    end

    assign last_ph = active && (ph == PH_B);
    assign sample  = last_ph && capture;

endmodule

// File: rtl/cle_key_reader.sv
// cle_key_reader: wins the shared bus, unlocks the CLE1C8 key with a fixed
// address pattern, then shifts KEY_BITS serial bits from sdrd into key_data.
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - cle_key_reader_if.master (host handshake + key bus)
// Parameters: KEY_BITS (1..32), GNT_TIMEOUT (1..65535 clocks in REQ).
// Optional: CLE_READ_PARITY_EN adds one trailing even-parity bit to READ;
// a mismatch reports error and leaves key_data untouched.
module cle_key_reader
    import cle_key_pkg::*;
#(
    parameter int KEY_BITS    = 16,
    parameter int GNT_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    cle_key_reader_if.master   bus
);

`ifdef CLE_READ_PARITY_EN
    localparam int NREAD = KEY_BITS + 1;
`else
    localparam int NREAD = KEY_BITS;
`endif
    localparam logic [5:0]  LAST_BIT = 6'(NREAD - 1);
    localparam logic [15:0] TO_MAX   = 16'(GNT_TIMEOUT);

    logic [2:0]          state;
    logic                busy_r, done_r, error_r, bus_req_r, gnt_q;
    logic [KEY_BITS-1:0] key_r, stage, stage_sh;
    logic [5:0]          bitcnt;
    logic [1:0]          idx;
    logic [15:0]         tocnt;

    logic                go, abort;
    logic [3:0]          nib;
    logic                seq_sser_n, seq_active, seq_sample, seq_last;
    logic [3:0]          seq_nib;

    cle_access_cycle u_acc (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .abort   (abort),
        .capture (state == S_READ),
        .nibble  (nib),
        .sser_n  (seq_sser_n),
        .ba_nib  (seq_nib),
        .active  (seq_active),
        .sample  (seq_sample),
        .last_ph (seq_last)
    );

    assign stage_sh = (stage << 1) | KEY_BITS'(bus.sdrd);

    // Next-access requests to the sequencer; only issued on the edge that
    // enters UNLOCK or ends a phase B, so accesses run back to back.
    always_comb begin
        go    = 1'b0;
        abort = 1'b0;
        nib   = 4'h0;
        case (state)
            S_REQ: if (gnt_q) begin
                go  = 1'b1;
                nib = unlock_nib(2'd0);
            end
            S_UNLOCK: begin
                if (!gnt_q) abort = 1'b1;
                else if (seq_last) begin
                    go  = 1'b1;
                    nib = (idx == 2'd3) ? 4'h0 : unlock_nib(idx + 2'd1);
                end
            end
            S_READ: begin
                if (!gnt_q) abort = 1'b1;
                else if (seq_sample && bitcnt != LAST_BIT) go = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            key_r     <= '0;
            stage     <= '0;
            bus_req_r <= 1'b0;
            gnt_q     <= 1'b0;
            bitcnt    <= 6'd0;
            idx       <= 2'd0;
            tocnt     <= 16'd0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            // grant only counts while we are asking for the bus
            gnt_q   <= bus.bus_gnt & bus_req_r;
            case (state)
                S_IDLE: if (bus.start) begin
                    state     <= S_REQ;
                    busy_r    <= 1'b1;
                    bus_req_r <= 1'b1;
                    tocnt     <= 16'd0;
                end
                S_REQ: begin
                    if (gnt_q) begin
                        state <= S_UNLOCK;
                        idx   <= 2'd0;
                    end else if (tocnt == TO_MAX) begin
                        state     <= S_FAIL;
                        error_r   <= 1'b1;
                        bus_req_r <= 1'b0;
                    end else begin
                        tocnt <= tocnt + 16'd1;
                    end
                end
                S_UNLOCK: begin
                    if (!gnt_q) begin
                        state     <= S_FAIL;
                        error_r   <= 1'b1;
                        bus_req_r <= 1'b0;
                    end else if (seq_last) begin
                        if (idx == 2'd3) begin
                            state  <= S_READ;
                            bitcnt <= 6'd0;
                            stage  <= '0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_READ: begin
                    if (!gnt_q) begin
                        state     <= S_FAIL;
                        error_r   <= 1'b1;
                        bus_req_r <= 1'b0;
                    end else if (seq_sample) begin
                        bitcnt <= bitcnt + 6'd1;
`ifdef CLE_READ_PARITY_EN
                        if (bitcnt == LAST_BIT) begin
                            bus_req_r <= 1'b0;
                            if ((^stage) == bus.sdrd) begin
                                state  <= S_RELEASE;
                                done_r <= 1'b1;
                                key_r  <= stage;
                            end else begin
                                state   <= S_FAIL;
                                error_r <= 1'b1;
                            end
                        end else begin
                            stage <= stage_sh;
                        end
`else
                        stage <= stage_sh;
                        if (bitcnt == LAST_BIT) begin
                            state     <= S_RELEASE;
                            done_r    <= 1'b1;
                            key_r     <= stage_sh;
                            bus_req_r <= 1'b0;
                        end
`endif
                    end
                end
                S_RELEASE, S_FAIL: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.error    = error_r;
    assign bus.key_data = key_r;
    assign bus.bus_req  = bus_req_r;
    assign bus.ba       = seq_active ? {KEY_WIN, 4'h0, seq_nib} : 10'h0;
    assign bus.br_w     = seq_active;
    // a dropped grant releases the select in the very cycle it is seen
    assign bus.sser_n   = seq_sser_n | ~gnt_q;

endmodule
